// File: rtl/midi_voice_alloc.sv
// MIDI byte-stream parser and polyphonic voice allocator with retrigger, oldest-voice stealing and all-notes-off.
// Optional sustain pedal (CC64) handling is compiled in with the macro MIDI_SUSTAIN_EN.
module midi_voice_alloc #(
    parameter int VOICES  = 8,
    parameter int V_WIDTH = $clog2(VOICES)
) (
    input  logic                  CLOCK_25,
    input  logic                  iRST_N,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_in,
    input  logic [15:0]           ch_mask,
    output logic [VOICES-1:0]     key_on,
    output logic [VOICES*4-1:0]   key_ch,
    output logic [VOICES*8-1:0]   key_val,
    output logic [VOICES*8-1:0]   vel,
    output logic [V_WIDTH:0]      active_keys,
    output logic                  ctrl_valid,
    output logic [3:0]            ctrl_ch,
    output logic [7:0]            ctrl_num,
    output logic [7:0]            ctrl_val,
    output logic                  pitch_valid,
    output logic [13:0]           pitch_val,
    output logic                  steal_pulse,
    output logic                  off_note_error
);

    typedef enum logic [1:0] {IDLE, DATA1, DATA2} state_t;

    localparam logic [V_WIDTH-1:0] AGE_MAX = V_WIDTH'(VOICES - 1);

    state_t state, next_state;
    logic [7:0] run_status;
    logic       accept;
    logic [6:0] d1_buf;
    logic       one_byte;
    logic       latch_status, clear_status, store_d1, finish;

    logic       msg_done;
    logic [7:0] msg_status;
    logic [6:0] msg_d1, msg_d2;
    logic [3:0] msg_ch, msg_type;
    logic       is_on, is_off, is_cc, is_pb, all_off;

    logic [V_WIDTH-1:0] age [VOICES];
    logic [VOICES-1:0]  hit, held;
    logic               match_found, free_found, held_found, off_found, stealing;
    logic [V_WIDTH-1:0] match_idx, free_idx, held_idx, off_idx, steal_idx, alloc_idx, best_age;
    logic               sustain_hit, cc64_release;

    assign one_byte = (run_status[7:5] == 3'b110);

    always_ff @(posedge CLOCK_25 or negedge iRST_N) begin
        if (!iRST_N) state <= IDLE;
        else         state <= next_state;
    end

    // Real-time bytes fall through untouched; system common bytes kill running status.
    always_comb begin
        next_state   = state;
        latch_status = 1'b0;
        clear_status = 1'b0;
        store_d1     = 1'b0;
        finish       = 1'b0;
        if (byte_valid) begin
            if (byte_in >= 8'hF8) begin
                next_state = state;
            end else if (byte_in >= 8'hF0) begin
                clear_status = 1'b1;
                next_state   = IDLE;
            end else if (byte_in[7]) begin
                latch_status = 1'b1;
                next_state   = DATA1;
            end else begin
                case (state)
                    DATA1: begin
                        if (one_byte) finish = 1'b1;
                        else begin
                            store_d1   = 1'b1;
                            next_state = DATA2;
                        end
                    end
                    DATA2: begin
                        finish     = 1'b1;
                        next_state = DATA1;
                    end
                    default: next_state = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge CLOCK_25 or negedge iRST_N) begin
        if (!iRST_N) begin
            run_status <= 8'h00;
            accept     <= 1'b0;
            d1_buf     <= 7'd0;
            msg_done   <= 1'b0;
            msg_status <= 8'h00;
            msg_d1     <= 7'd0;
            msg_d2     <= 7'd0;
        end else begin
            msg_done <= finish & accept;
            if (latch_status) begin
                run_status <= byte_in;
                accept     <= ch_mask[byte_in[3:0]];
            end
            if (clear_status) begin
                run_status <= 8'h00;
                accept     <= 1'b0;
            end
            if (store_d1) d1_buf <= byte_in[6:0];
            if (finish) begin
                msg_status <= run_status;
                msg_d1     <= one_byte ? byte_in[6:0] : d1_buf;
                msg_d2     <= one_byte ? 7'd0 : byte_in[6:0];
            end
        end
    end

    assign msg_ch   = msg_status[3:0];
    assign msg_type = msg_status[7:4];
    assign is_on    = msg_done && (msg_type == 4'h9) && (msg_d2 != 7'd0);
    assign is_off   = msg_done && ((msg_type == 4'h8) || ((msg_type == 4'h9) && (msg_d2 == 7'd0)));
    assign is_cc    = msg_done && (msg_type == 4'hB);
    assign is_pb    = msg_done && (msg_type == 4'hE);
    assign all_off  = is_cc && (msg_d1 == 7'd123);

    // Descending scans leave the lowest matching index; the age scan keeps the first maximum.
    always_comb begin
        hit         = '0;
        match_found = 1'b0;
        match_idx   = '0;
        free_found  = 1'b0;
        free_idx    = '0;
        held_found  = 1'b0;
        held_idx    = '0;
        off_found   = 1'b0;
        off_idx     = '0;
        for (int i = VOICES - 1; i >= 0; i--) begin
            hit[i] = key_on[i] && (key_ch[i*4 +: 4] == msg_ch) && (key_val[i*8 +: 8] == {1'b0, msg_d1});
            if (hit[i]) begin
                match_found = 1'b1;
                match_idx   = V_WIDTH'(i);
            end
            if (hit[i] && !held[i]) begin
                off_found = 1'b1;
                off_idx   = V_WIDTH'(i);
            end
            if (!key_on[i]) begin
                free_found = 1'b1;
                free_idx   = V_WIDTH'(i);
            end
            if (held[i]) begin
                held_found = 1'b1;
                held_idx   = V_WIDTH'(i);
            end
        end
        best_age  = age[0];
        steal_idx = '0;
        for (int i = 1; i < VOICES; i++) begin
            if (age[i] > best_age) begin
                best_age  = age[i];
                steal_idx = V_WIDTH'(i);
            end
        end
        stealing  = 1'b0;
        alloc_idx = steal_idx;
        if (match_found)     alloc_idx = match_idx;
        else if (free_found) alloc_idx = free_idx;
        else if (held_found) begin
            alloc_idx = held_idx;
            stealing  = 1'b1;
        end else stealing = 1'b1;
    end

`ifdef MIDI_SUSTAIN_EN
    logic [15:0] sustain;

    assign sustain_hit  = sustain[msg_ch];
    assign cc64_release = is_cc && (msg_d1 == 7'd64) && !msg_d2[6];

    always_ff @(posedge CLOCK_25 or negedge iRST_N) begin
        if (!iRST_N) begin
            sustain <= '0;
            held    <= '0;
        end else begin
            if (is_cc && (msg_d1 == 7'd64)) sustain[msg_ch] <= msg_d2[6];
            for (int i = 0; i < VOICES; i++) begin
                if (is_on && (V_WIDTH'(i) == alloc_idx))
                    held[i] <= 1'b0;
                else if (is_off && sustain_hit && off_found && (V_WIDTH'(i) == off_idx))
                    held[i] <= 1'b1;
                else if ((all_off || cc64_release) && (key_ch[i*4 +: 4] == msg_ch))
                    held[i] <= 1'b0;
            end
        end
    end
`else
    assign held         = '0;
    assign sustain_hit  = 1'b0;
    assign cc64_release = 1'b0;
`endif

    // Voice table: at most one message lands per cycle, so the branches never compete.
    always_ff @(posedge CLOCK_25 or negedge iRST_N) begin
        if (!iRST_N) begin
            key_on         <= '0;
            key_ch         <= '0;
            key_val        <= {VOICES{8'hFF}};
            vel            <= '0;
            for (int i = 0; i < VOICES; i++) age[i] <= '0;
            steal_pulse    <= 1'b0;
            ctrl_valid     <= 1'b0;
            ctrl_ch        <= 4'd0;
            ctrl_num       <= 8'd0;
            ctrl_val       <= 8'd0;
            pitch_valid    <= 1'b0;
            pitch_val      <= 14'h2000;
            off_note_error <= 1'b0;
        end else begin
            steal_pulse <= is_on && stealing;
            ctrl_valid  <= is_cc;
            pitch_valid <= is_pb;
            if (is_cc) begin
                ctrl_ch  <= msg_ch;
                ctrl_num <= {1'b0, msg_d1};
                ctrl_val <= {1'b0, msg_d2};
            end
            if (is_pb) pitch_val <= {msg_d2, msg_d1};
            if (is_off && !off_found) off_note_error <= 1'b1;
            if (all_off) off_note_error <= 1'b0;
            for (int i = 0; i < VOICES; i++) begin
                if (is_on) begin
                    if (V_WIDTH'(i) == alloc_idx) begin
                        key_on[i]         <= 1'b1;
                        key_ch[i*4 +: 4]  <= msg_ch;
                        key_val[i*8 +: 8] <= {1'b0, msg_d1};
                        vel[i*8 +: 8]     <= {1'b0, msg_d2};
                        age[i]            <= '0;
                    end else if (key_on[i] && (age[i] != AGE_MAX)) begin
                        age[i] <= age[i] + 1'b1;
                    end
                end
                if (is_off && off_found && !sustain_hit && (V_WIDTH'(i) == off_idx)) begin
                    key_on[i]         <= 1'b0;
                    key_val[i*8 +: 8] <= 8'hFF;
                    vel[i*8 +: 8]     <= {1'b0, msg_d2};
                    age[i]            <= '0;
                end
                if ((all_off || (cc64_release && held[i])) && key_on[i] && (key_ch[i*4 +: 4] == msg_ch)) begin
                    key_on[i]         <= 1'b0;
                    key_val[i*8 +: 8] <= 8'hFF;
                    vel[i*8 +: 8]     <= 8'h00;
                    age[i]            <= '0;
                end
            end
        end
    end

    always_comb begin
        active_keys = '0;
        for (int i = 0; i < VOICES; i++) active_keys = active_keys + (V_WIDTH + 1)'(key_on[i]);
    end

endmodule

// File: tb/tb_midi_voice_alloc.sv
// Directed-vector bench for midi_voice_alloc: a message table plus hand-written stealing, masking,
// sustain (MIDI_SUSTAIN_EN) and mid-message reset sequences.
module tb_midi_voice_alloc;

    localparam int VOICES = 8;
    localparam int VW     = 3;

    logic                CLOCK_25 = 1'b0;
    logic                iRST_N;
    logic                byte_valid;
    logic [7:0]          byte_in;
    logic [15:0]         ch_mask;
    logic [VOICES-1:0]   key_on;
    logic [VOICES*4-1:0] key_ch;
    logic [VOICES*8-1:0] key_val;
    logic [VOICES*8-1:0] vel;
    logic [VW:0]         active_keys;
    logic                ctrl_valid;
    logic [3:0]          ctrl_ch;
    logic [7:0]          ctrl_num;
    logic [7:0]          ctrl_val;
    logic                pitch_valid;
    logic [13:0]         pitch_val;
    logic                steal_pulse;
    logic                off_note_error;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          n;
        logic [7:0]  b0, b1, b2;
        logic [7:0]  kon;
        logic [3:0]  act;
        logic        err, ctrl, pv, st;
        logic [13:0] pval;
        int          v;
        logic [7:0]  key, velo;
    } vec_t;

    vec_t vecs [11];

    midi_voice_alloc #(.VOICES(VOICES)) dut (
        .CLOCK_25       (CLOCK_25),
        .iRST_N         (iRST_N),
        .byte_valid     (byte_valid),
        .byte_in        (byte_in),
        .ch_mask        (ch_mask),
        .key_on         (key_on),
        .key_ch         (key_ch),
        .key_val        (key_val),
        .vel            (vel),
        .active_keys    (active_keys),
        .ctrl_valid     (ctrl_valid),
        .ctrl_ch        (ctrl_ch),
        .ctrl_num       (ctrl_num),
        .ctrl_val       (ctrl_val),
        .pitch_valid    (pitch_valid),
        .pitch_val      (pitch_val),
        .steal_pulse    (steal_pulse),
        .off_note_error (off_note_error)
    );

    always #20 CLOCK_25 = ~CLOCK_25;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Entered and left on a falling edge; the byte is consumed by the rising edge in between.
    task automatic send_byte(input logic [7:0] b);
        byte_valid = 1'b1;
        byte_in    = b;
        @(negedge CLOCK_25);
        byte_valid = 1'b0;
        byte_in    = 8'h00;
    endtask

    task automatic apply_stimulus(input int n, input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        send_byte(b0);
        if (n > 1) send_byte(b1);
        if (n > 2) send_byte(b2);
        @(negedge CLOCK_25);
    endtask

    task automatic do_reset();
        iRST_N = 1'b0;
        @(negedge CLOCK_25);
        @(negedge CLOCK_25);
        iRST_N = 1'b1;
        @(negedge CLOCK_25);
    endtask

    initial begin
        int steals;
        iRST_N     = 1'b1;
        byte_valid = 1'b0;
        byte_in    = 8'h00;
        ch_mask    = 16'hFFFF;

        vecs[0]  = '{3, 8'h90, 8'h3C, 8'h64, 8'h01, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 14'h2000,  0, 8'h3C, 8'h64};
        vecs[1]  = '{2, 8'h3E, 8'h50, 8'h00, 8'h03, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 14'h2000,  1, 8'h3E, 8'h50};
        vecs[2]  = '{2, 8'h3C, 8'h00, 8'h00, 8'h02, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 14'h2000,  0, 8'hFF, 8'h00};
        vecs[3]  = '{3, 8'h80, 8'h40, 8'h00, 8'h02, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 14'h2000, -1, 8'h00, 8'h00};
        vecs[4]  = '{3, 8'hB0, 8'h7B, 8'h00, 8'h00, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 14'h2000,  1, 8'hFF, 8'h00};
        vecs[5]  = '{3, 8'hE0, 8'h01, 8'h40, 8'h00, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 14'h2001, -1, 8'h00, 8'h00};
        vecs[6]  = '{3, 8'h91, 8'h3C, 8'h64, 8'h01, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 14'h2001,  0, 8'h3C, 8'h64};
        vecs[7]  = '{3, 8'h81, 8'h3C, 8'h22, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 14'h2001,  0, 8'hFF, 8'h22};
        vecs[8]  = '{2, 8'hC0, 8'h05, 8'h00, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 14'h2001, -1, 8'h00, 8'h00};
        vecs[9]  = '{3, 8'h92, 8'h3C, 8'h64, 8'h01, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 14'h2001,  0, 8'h3C, 8'h64};
        vecs[10] = '{3, 8'hB2, 8'h7B, 8'h00, 8'h00, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 14'h2001,  0, 8'hFF, 8'h00};

        @(negedge CLOCK_25);
        do_reset();
        check_output("reset key_on", 32'(key_on), 32'h0);
        check_output("reset key_val", key_val[31:0], 32'hFFFF_FFFF);
        check_output("reset pitch_val", 32'(pitch_val), 32'h2000);
        check_output("reset active_keys", 32'(active_keys), 32'h0);

        for (int i = 0; i < 11; i++) begin
            apply_stimulus(vecs[i].n, vecs[i].b0, vecs[i].b1, vecs[i].b2);
            check_output($sformatf("vec%0d key_on", i), 32'(key_on), 32'(vecs[i].kon));
            check_output($sformatf("vec%0d active_keys", i), 32'(active_keys), 32'(vecs[i].act));
            check_output($sformatf("vec%0d off_note_error", i), 32'(off_note_error), 32'(vecs[i].err));
            check_output($sformatf("vec%0d ctrl_valid", i), 32'(ctrl_valid), 32'(vecs[i].ctrl));
            check_output($sformatf("vec%0d pitch_valid", i), 32'(pitch_valid), 32'(vecs[i].pv));
            check_output($sformatf("vec%0d steal_pulse", i), 32'(steal_pulse), 32'(vecs[i].st));
            check_output($sformatf("vec%0d pitch_val", i), 32'(pitch_val), 32'(vecs[i].pval));
            if (vecs[i].v >= 0) begin
                check_output($sformatf("vec%0d key_val", i), 32'(key_val[vecs[i].v*8 +: 8]), 32'(vecs[i].key));
                check_output($sformatf("vec%0d vel", i), 32'(vel[vecs[i].v*8 +: 8]), 32'(vecs[i].velo));
            end
        end

        // One-cycle latency, then fill all eight voices and steal the oldest twice.
        do_reset();
        send_byte(8'h90);
        send_byte(8'h40);
        send_byte(8'h10);
        check_output("latency before", 32'(key_on), 32'h00);
        @(negedge CLOCK_25);
        check_output("latency after", 32'(key_on), 32'h01);
        steals = 0;
        for (int k = 1; k < 8; k++) begin
            apply_stimulus(2, 8'(8'h40 + k), 8'h10, 8'h00);
            if (steal_pulse) steals++;
        end
        check_output("fill active_keys", 32'(active_keys), 32'd8);
        apply_stimulus(2, 8'h48, 8'h11, 8'h00);
        check_output("steal9 pulse", 32'(steal_pulse), 32'h1);
        if (steal_pulse) steals++;
        check_output("steal9 voice0 key", 32'(key_val[7:0]), 32'h48);
        check_output("steal9 active_keys", 32'(active_keys), 32'd8);
        @(negedge CLOCK_25);
        check_output("steal pulse width", 32'(steal_pulse), 32'h0);
        check_output("steal count", 32'(steals), 32'd1);
        apply_stimulus(2, 8'h49, 8'h12, 8'h00);
        check_output("steal10 voice1 key", 32'(key_val[15:8]), 32'h49);
        apply_stimulus(2, 8'h48, 8'h20, 8'h00);
        check_output("retrigger vel", 32'(vel[7:0]), 32'h20);
        check_output("retrigger no steal", 32'(steal_pulse), 32'h0);
        check_output("retrigger key_on", 32'(key_on), 32'hFF);

        // Channel mask, real-time bytes mid-message and system-exclusive dropping running status.
        ch_mask = 16'h0001;
        do_reset();
        apply_stimulus(3, 8'h91, 8'h3C, 8'h64);
        check_output("masked ch1", 32'(key_on), 32'h00);
        send_byte(8'h90);
        send_byte(8'hF8);
        send_byte(8'h3C);
        send_byte(8'hF8);
        send_byte(8'h64);
        @(negedge CLOCK_25);
        check_output("realtime key_on", 32'(key_on), 32'h01);
        check_output("realtime key", 32'(key_val[7:0]), 32'h3C);
        send_byte(8'hF0);
        send_byte(8'h3C);
        send_byte(8'h64);
        send_byte(8'hF7);
        apply_stimulus(2, 8'h3E, 8'h50, 8'h00);
        check_output("sysex drop", 32'(key_on), 32'h01);
        ch_mask = 16'hFFFF;

        // Sustain pedal behaviour depends on the build.
        do_reset();
        apply_stimulus(3, 8'h90, 8'h3C, 8'h64);
        apply_stimulus(3, 8'hB0, 8'h40, 8'h7F);
        check_output("cc64 ctrl_valid", 32'(ctrl_valid), 32'h1);
        check_output("cc64 ctrl_num", 32'(ctrl_num), 32'h40);
        check_output("cc64 ctrl_val", 32'(ctrl_val), 32'h7F);
        apply_stimulus(3, 8'h80, 8'h3C, 8'h00);
`ifdef MIDI_SUSTAIN_EN
        check_output("sustain held", 32'(key_on), 32'h01);
        apply_stimulus(3, 8'hB0, 8'h40, 8'h00);
        check_output("sustain release", 32'(key_on), 32'h00);
        check_output("sustain release key", 32'(key_val[7:0]), 32'hFF);
`else
        check_output("no sustain release", 32'(key_on), 32'h00);
        check_output("no sustain error", 32'(off_note_error), 32'h0);
`endif

        // Reset in the middle of a message from a non-reset state.
        apply_stimulus(3, 8'hE0, 8'h7F, 8'h7F);
        apply_stimulus(3, 8'h90, 8'h50, 8'h33);
        apply_stimulus(3, 8'h80, 8'h70, 8'h00);
        check_output("pre-reset error", 32'(off_note_error), 32'h1);
        send_byte(8'h90);
        send_byte(8'h3E);
        iRST_N = 1'b0;
        @(negedge CLOCK_25);
        check_output("midreset key_on", 32'(key_on), 32'h00);
        check_output("midreset key_val", key_val[31:0], 32'hFFFF_FFFF);
        check_output("midreset vel", vel[31:0], 32'h0);
        check_output("midreset key_ch", key_ch, 32'h0);
        check_output("midreset pitch_val", 32'(pitch_val), 32'h2000);
        check_output("midreset error", 32'(off_note_error), 32'h0);
        check_output("midreset active_keys", 32'(active_keys), 32'h0);
        iRST_N = 1'b1;
        @(negedge CLOCK_25);
        apply_stimulus(1, 8'h50, 8'h00, 8'h00);
        check_output("partial discarded", 32'(key_on), 32'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/midi_voice_alloc.md
MIDI_VOICE_ALLOC -- requirements
Module: midi_voice_alloc

Interface
REQ-001 SHALL have parameter VOICES, default 8, meaning number of voice slots (2..32).
REQ-002 SHALL have parameter V_WIDTH, default clog2(VOICES), meaning voice-index width.
REQ-003 SHALL have port CLOCK_25  in  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port iRST_N  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports byte_valid  in  1  and byte_in  in  8: one raw MIDI byte per byte_valid cycle, from the UART.
REQ-006 SHALL have port ch_mask  in  16  channel-accept mask; bit n accepts MIDI channel n.
REQ-007 SHALL have ports key_on, key_ch, key_val, vel  out  VOICES, VOICES*4, VOICES*8, VOICES*8: per-voice gate, channel, note and velocity.
REQ-008 SHALL have port active_keys  out  V_WIDTH+1  count of voices with key_on=1.
REQ-009 SHALL have ports ctrl_valid, ctrl_ch, ctrl_num, ctrl_val  out  1,4,8,8  and pitch_valid, pitch_val  out  1,14.
REQ-010 SHALL have ports steal_pulse, off_note_error  out  1,1.

Function
REQ-011 SHALL parse with FSM IDLE, DATA1, DATA2; status byte 0x80-0xEF latches running status, sets expected length (1 for 0xC/0xD, else 2), goes DATA1.
REQ-012 SHALL ignore bytes 0xF8-0xFF with no change to state or running status.
REQ-013 SHALL, on 0xF0-0xF7, clear running status and discard data bytes until next channel status.
REQ-014 SHALL, after final data byte, return to DATA1 (running status); data byte in IDLE without status SHALL be dropped.
REQ-015 SHALL drop whole messages whose channel bit in ch_mask is 0; ch_mask sampled at status byte.
REQ-016 SHALL update voice outputs exactly 1 cycle after final data byte of an accepted message.
REQ-017 SHALL treat note-on with velocity 0 as note-off.
REQ-018 SHALL, on note-on matching an active voice (same ch, key), retrigger it: vel updated, age 0, no new voice.
REQ-019 SHALL otherwise allocate lowest-index free voice; if none, steal voice with highest age (ties: lowest index), pulse steal_pulse 1 cycle.
REQ-020 SHALL keep per-voice age 0..VOICES-1: allocated/retriggered voice gets 0, every other active voice increments, saturating.
REQ-021 SHALL, on note-off, release lowest-index active voice matching ch and key: key_on=0, key_val=0xFF, vel=release velocity.
REQ-022 SHALL set off_note_error sticky when note-off matches no voice; clear on CC 123 or reset.
REQ-023 SHALL, on CC 123 (all notes off), release all voices of that channel in one cycle.
REQ-024 SHALL pulse ctrl_valid 1 cycle for every accepted CC (0xB) and pitch_valid for pitch bend with pitch_val={d2[6:0],d1[6:0]}.
REQ-025 SHALL keep active_keys equal to popcount(key_on) every cycle.
REQ-026 SHALL give note-off priority over CC 123 never collide: one message completes per cycle max.

Reset
REQ-027 SHALL on iRST_N low: FSM IDLE, running status cleared, key_on=0, key_val=0xFF, vel=0, key_ch=0, ages 0, active_keys=0, all pulses 0, off_note_error=0, pitch_val=0x2000.
REQ-028 SHALL discard any partial message on reset mid-message.

Configuration
REQ-029 SHALL compile sustain logic only with macro MIDI_SUSTAIN_EN defined.
REQ-030 SHALL, with MIDI_SUSTAIN_EN: CC64 value>=64 sets channel sustain; note-off on sustained channel marks voice held (key_on stays 1); CC64<64 releases all held voices of that channel; held voices are free for stealing first (lowest index).
REQ-031 SHALL, without MIDI_SUSTAIN_EN: CC64 only reported via ctrl_valid, note-off releases immediately.

Verification
REQ-032 90 3C 64, then 3E 50 (running status) -> voice0 key 0x3C vel 0x64, voice1 key 0x3E vel 0x50, active_keys=2.
REQ-033 VOICES=8, 9 distinct note-ons ch0 -> 9th steals voice0 (oldest), steal_pulse once, active_keys=8.
REQ-034 90 3C 00 after 90 3C 64 -> voice0 released, key_val 0xFF, active_keys=0; 80 40 00 unmatched -> off_note_error=1.
REQ-035 ch_mask=0x0001, 91 3C 64 -> no change; 90 3C 64 F8 -> F8 ignored, note allocated.
REQ-036 MIDI_SUSTAIN_EN: B0 40 7F, 80 3C 00 -> key_on stays 1; B0 40 00 -> released; reset asserted mid DATA2 -> all outputs reset values.
